// File: rtl/axil_if.sv
// rtl/axil_if.sv - AXI-Lite bus bundle with manager and peripheral views
// Parameters: DATA_WIDTH, ADDRESS_WIDTH.
// Signals: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//          B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//          R (rdata/rresp/rvalid/rready).
interface axil_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) ();
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport peripheral (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport manager (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_regfile.sv
// rtl/axil_regfile.sv - AXI-Lite register file with RO status slots and byte-strobed writes
// Optional feature macro: AXIL_REGFILE_ERR_EN (SLVERR on out-of-range / RO accesses).
// Ports:
//   clock     - single clock
//   reset_n   - asynchronous active-low reset
//   axil      - AXI-Lite peripheral port (axil_if.peripheral)
//   regs_out  - RW register contents, slot i at [i*DATA_WIDTH +: DATA_WIDTH], RO slots 0
//   regs_in   - hardware values returned for RO slots
//   wr_pulse  - one-cycle strobe per register on write commit
module axil_regfile #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 32,
    parameter int                    NUM_REGS      = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK       = NUM_REGS'(8'h80),
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                           clock,
    input  logic                           reset_n,
    axil_if.peripheral                     axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
    logic                     ready_en;
    logic                     aw_full;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic                     w_full;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_W-1:0]        w_strb_q;
    logic                     b_valid;
    logic [1:0]               b_resp;
    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [1:0]               r_resp;

    // Address decode for the held write and the incoming read
    logic [ADDRESS_WIDTH-1:0] aw_word;
    logic [ADDRESS_WIDTH-1:0] ar_word;
    logic [IDX_W-1:0]         aw_idx;
    logic [IDX_W-1:0]         ar_idx;
    logic                     aw_in_range;
    logic                     ar_in_range;
    logic                     wr_ok;
    logic [DATA_WIDTH-1:0]    rd_value;

    assign aw_word     = aw_addr_q >> ADDR_LSB;
    assign ar_word     = axil.araddr >> ADDR_LSB;
    assign aw_idx      = aw_word[IDX_W-1:0];
    assign ar_idx      = ar_word[IDX_W-1:0];
    assign aw_in_range = aw_word < ADDRESS_WIDTH'(NUM_REGS);
    assign ar_in_range = ar_word < ADDRESS_WIDTH'(NUM_REGS);
    assign wr_ok       = aw_in_range && !RO_MASK[aw_idx];

    always_comb begin
        rd_value = '0;
        if (ar_in_range) begin
            if (RO_MASK[ar_idx])
                rd_value = regs_in[ar_idx*DATA_WIDTH +: DATA_WIDTH];
            else
                rd_value = regs[ar_idx];
        end
    end

    // Handshake and commit conditions
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;

    assign axil.awready = ready_en && !aw_full;
    assign axil.wready  = ready_en && !w_full;
    assign axil.arready = ready_en && !r_valid;
    assign axil.bvalid  = b_valid;
    assign axil.bresp   = b_resp;
    assign axil.rvalid  = r_valid;
    assign axil.rdata   = r_data;
    assign axil.rresp   = r_resp;

    assign aw_hs  = axil.awvalid && axil.awready;
    assign w_hs   = axil.wvalid && axil.wready;
    assign ar_hs  = axil.arvalid && axil.arready;
    // A complete pair waits for the previous response to drain
    assign commit = aw_full && w_full && !b_valid;

    logic unused_prot;
    assign unused_prot = ^{axil.awprot, axil.arprot};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VALUE;
            ready_en  <= 1'b0;
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
            w_full    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid   <= 1'b0;
            b_resp    <= RESP_OKAY;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_resp    <= RESP_OKAY;
            wr_pulse  <= '0;
        end else begin
            ready_en <= 1'b1;
            wr_pulse <= '0;

            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= axil.awaddr;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= axil.wdata;
                w_strb_q <= axil.wstrb;
            end

            if (b_valid && axil.bready)
                b_valid <= 1'b0;

            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                b_valid <= 1'b1;
`ifdef AXIL_REGFILE_ERR_EN
                b_resp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
`else
                b_resp  <= RESP_OKAY;
`endif
                if (wr_ok) begin
                    for (int j = 0; j < STRB_W; j++)
                        if (w_strb_q[j])
                            regs[aw_idx][j*8 +: 8] <= w_data_q[j*8 +: 8];
                    if (|w_strb_q)
                        wr_pulse[aw_idx] <= 1'b1;
                end
            end

            // rd_value samples pre-write contents when a commit hits the same edge
            if (ar_hs) begin
                r_valid <= 1'b1;
                r_data  <= rd_value;
`ifdef AXIL_REGFILE_ERR_EN
                r_resp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
`else
                r_resp  <= RESP_OKAY;
`endif
            end else if (r_valid && axil.rready) begin
                r_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : gen_regs_out
        assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end
endmodule

// File: tb/tb_axil_regfile.sv
// tb/tb_axil_regfile.sv - scoreboard bench for axil_regfile
module tb_axil_regfile;
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [255:0] regs_out;
    logic [255:0] regs_in;
    logic [7:0]   wr_pulse;

    axil_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) axil ();

    axil_regfile dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .axil     (axil),
        .regs_out (regs_out),
        .regs_in  (regs_in),
        .wr_pulse (wr_pulse)
    );

    always #5 clock = ~clock;

`ifdef AXIL_REGFILE_ERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    int total = 0;
    int bad = 0;
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];
    logic [1:0]  mon_b;
    logic [33:0] mon_r;
    logic [255:0] exp_regs;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected want response", name);
    endtask

    // Monitor: every negedge with valid & ready is exactly one handshake at the next edge
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && axil.bvalid && axil.bready) begin
                if (b_q.size() == 0) fail_now("b_unexpected");
                else begin
                    mon_b = b_q.pop_front();
                    check("bresp", axil.bresp, mon_b);
                end
            end
            if (reset_n && axil.rvalid && axil.rready) begin
                if (r_q.size() == 0) fail_now("r_unexpected");
                else begin
                    mon_r = r_q.pop_front();
                    check("rdata", axil.rdata, mon_r[33:2]);
                    check("rresp", axil.rresp, mon_r[1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] addr);
        int n = 0;
        axil.awaddr = addr;
        axil.awvalid = 1'b1;
        @(negedge clock);
        while (!axil.awready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!axil.awready) fail_now("aw_timeout");
        @(posedge clock);
        #1;
        axil.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        axil.wdata = data;
        axil.wstrb = strb;
        axil.wvalid = 1'b1;
        @(negedge clock);
        while (!axil.wready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!axil.wready) fail_now("w_timeout");
        @(posedge clock);
        #1;
        axil.wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr);
        int n = 0;
        axil.araddr = addr;
        axil.arvalid = 1'b1;
        @(negedge clock);
        while (!axil.arready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!axil.arready) fail_now("ar_timeout");
        @(posedge clock);
        #1;
        axil.arvalid = 1'b0;
    endtask

    task automatic write_req(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        b_q.push_back(exp_resp);
        fork
            aw_send(addr);
            w_send(data, strb);
        join
    endtask

    task automatic wait_b_empty(input string name);
        int n = 0;
        while (b_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (b_q.size() != 0) begin
            fail_now(name);
            b_q.delete();
        end
    endtask

    task automatic wait_r_empty(input string name);
        int n = 0;
        while (r_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (r_q.size() != 0) begin
            fail_now(name);
            r_q.delete();
        end
    endtask

    task automatic read_req(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        r_q.push_back({exp_data, exp_resp});
        ar_send(addr);
        @(negedge clock);
        check("r_latency", axil.rvalid, 1'b1);
        wait_r_empty("r_timeout");
    endtask

    initial begin
        axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 1'b0;
        axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0;
        axil.bready = 1'b1;
        axil.araddr = '0; axil.arprot = '0; axil.arvalid = 1'b0;
        axil.rready = 1'b1;
        regs_in = '0;

        // Reset state
        @(negedge clock);
        check("rst_ready", {axil.awready, axil.wready, axil.arready}, 3'b000);
        check("rst_valid", {axil.bvalid, axil.rvalid}, 2'b00);
        check("rst_resp", {axil.bresp, axil.rresp, axil.rdata}, 36'h0);
        check("rst_regs", regs_out, 256'h0);
        check("rst_pulse", wr_pulse, 8'h00);
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_pre", {axil.awready, axil.wready, axil.arready}, 3'b000);
        @(negedge clock);
        check("ready_post", {axil.awready, axil.wready, axil.arready}, 3'b111);

        // Basic write + read, latency checks
        step();
        write_req(32'h00, 32'hDEADBEEF, 4'hF, 2'b00);
        @(negedge clock);
        check("b_not_early", axil.bvalid, 1'b0);
        check("pulse_not_early", wr_pulse, 8'h00);
        @(negedge clock);
        check("b_latency", axil.bvalid, 1'b1);
        check("pulse0", wr_pulse, 8'h01);
        check("reg0_visible", regs_out[31:0], 32'hDEADBEEF);
        @(negedge clock);
        check("pulse0_off", wr_pulse, 8'h00);
        wait_b_empty("b_timeout_1");
        step();
        read_req(32'h00, 32'hDEADBEEF, 2'b00);

        // W three cycles ahead of AW, partial strobes
        step();
        write_req(32'h04, 32'hFFFFFFFF, 4'hF, 2'b00);
        wait_b_empty("b_timeout_2");
        step();
        b_q.push_back(2'b00);
        w_send(32'h11223344, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("wready_held", axil.wready, 1'b0);
            check("awready_free", axil.awready, 1'b1);
            check("no_commit_w_only", axil.bvalid, 1'b0);
        end
        step();
        aw_send(32'h04);
        @(negedge clock);
        check("awready_held", axil.awready, 1'b0);
        wait_b_empty("b_timeout_3");
        check("reg1_strobe", regs_out[63:32], 32'hFF22FF44);

        // RO register 7
        step();
        regs_in[255:224] = 32'h0000CAFE;
        write_req(32'h1C, 32'h12345678, 4'hF, ERR_RESP);
        @(negedge clock);
        check("ro_pulse_a", wr_pulse, 8'h00);
        @(negedge clock);
        check("ro_pulse_b", wr_pulse, 8'h00);
        wait_b_empty("b_timeout_4");
        check("ro_regs_out", regs_out[255:224], 32'h0);
        step();
        read_req(32'h1C, 32'h0000CAFE, 2'b00);

        // Out of range index 8
        exp_regs = '0;
        exp_regs[31:0] = 32'hDEADBEEF;
        exp_regs[63:32] = 32'hFF22FF44;
        step();
        read_req(32'h20, 32'h0, ERR_RESP);
        step();
        write_req(32'h20, 32'h12345678, 4'hF, ERR_RESP);
        @(negedge clock);
        @(negedge clock);
        check("oor_pulse", wr_pulse, 8'h00);
        wait_b_empty("b_timeout_5");
        check("oor_regs", regs_out, exp_regs);

        // Back-pressure on B with a second write queued behind it
        step();
        axil.bready = 1'b0;
        write_req(32'h08, 32'hAAAA5555, 4'hF, 2'b00);
        @(negedge clock);
        @(negedge clock);
        check("bp_bvalid", axil.bvalid, 1'b1);
        step();
        write_req(32'h0C, 32'h0BADF00D, 4'hF, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_bvalid_stable", axil.bvalid, 1'b1);
            check("bp_bresp_stable", axil.bresp, 2'b00);
            check("bp_both_full", {axil.awready, axil.wready}, 2'b00);
            check("bp_reg3_waits", regs_out[127:96], 32'h0);
        end
        step();
        axil.bready = 1'b1;
        wait_b_empty("b_timeout_6");
        check("bp_reg2", regs_out[95:64], 32'hAAAA5555);
        check("bp_reg3", regs_out[127:96], 32'h0BADF00D);

        // Reset mid-transaction
        step();
        axil.bready = 1'b0;
        write_req(32'h10, 32'h00000055, 4'hF, 2'b00);
        @(negedge clock);
        @(negedge clock);
        check("mid_bvalid", axil.bvalid, 1'b1);
        check("mid_reg4", regs_out[159:128], 32'h55);
        step();
        aw_send(32'h14);
        #3;
        reset_n = 1'b0;
        #1;
        b_q.delete();
        check("mid_rst_ready", {axil.awready, axil.wready, axil.arready}, 3'b000);
        check("mid_rst_bvalid", axil.bvalid, 1'b0);
        check("mid_rst_regs", regs_out, 256'h0);
        step();
        reset_n = 1'b1;
        axil.bready = 1'b1;
        @(negedge clock);
        check("mid_ready_pre", {axil.awready, axil.wready, axil.arready}, 3'b000);
        @(negedge clock);
        check("mid_ready_post", {axil.awready, axil.wready, axil.arready}, 3'b111);
        check("mid_no_b", axil.bvalid, 1'b0);

        // Fresh write after reset onto RESET_VALUE
        step();
        write_req(32'h04, 32'hABCD1234, 4'b0011, 2'b00);
        wait_b_empty("b_timeout_7");
        step();
        read_req(32'h04, 32'h00001234, 2'b00);

        check("b_q_drained", b_q.size(), 0);
        check("r_q_drained", r_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
